// File: rtl/ndma_mc.sv
// Multi-channel word-copy DMA: round-robin over NumCh descriptors, OBI read/write managers, Depth-entry data FIFO.
// Optional NDMA_MC_ERR_EN adds rd_err_i/wr_err_i: abort, drain, flush, flag STATUS.err.
module ndma_mc #(
  parameter int NumCh     = 4,
  parameter int Depth     = 4,
  parameter int MaxTxSize = 256,
  parameter int DataWidth = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cfg_req_i,
  input  logic                   cfg_we_i,
  input  logic [31:0]            cfg_addr_i,
  input  logic [31:0]            cfg_wdata_i,
  output logic                   cfg_gnt_o,
  output logic [31:0]            cfg_rdata_o,
  output logic                   cfg_rvalid_o,
  output logic                   rd_req_o,
  output logic [31:0]            rd_addr_o,
  input  logic                   rd_gnt_i,
  input  logic                   rd_rvalid_i,
  input  logic [DataWidth-1:0]   rd_rdata_i,
`ifdef NDMA_MC_ERR_EN
  input  logic                   rd_err_i,
  input  logic                   wr_err_i,
`endif
  output logic                   wr_req_o,
  output logic [31:0]            wr_addr_o,
  output logic [DataWidth-1:0]   wr_wdata_o,
  output logic [DataWidth/8-1:0] wr_be_o,
  input  logic                   wr_gnt_i,
  input  logic                   wr_rvalid_i,
  output logic [NumCh-1:0]       irq_o
);
  localparam int CW  = $clog2(MaxTxSize + 1);
  localparam int CHW = (NumCh > 1) ? $clog2(NumCh) : 1;
  localparam int PW  = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int OW  = $clog2(2 * Depth + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;

  logic [31:0]    src_q [NumCh];
  logic [31:0]    dst_q [NumCh];
  logic [CW-1:0]  len_q [NumCh];
  logic [31:0]    stride_q [NumCh];
  logic [NumCh-1:0] pend_q, done_q, err_q, done_n, err_n, irq_en_q, irq_q;

  logic [CHW-1:0] cur_q, last_q, pick;
  logic           found, start, finish, abort_q, err_hit;
  logic [CW-1:0]  j_len, rd_iss, wr_iss, wr_cnt;
  logic [31:0]    rd_addr_q, wr_addr_q;
  logic [15:0]    j_ss, j_ds;
  logic [OW-1:0]  out_cnt, fifo_cnt;
  logic [PW-1:0]  wptr, rptr;
  logic [DataWidth-1:0] mem [Depth];
  logic           rd_req, wr_req, rd_go, wr_go, rd_rsp, wr_rsp, push, pop, busy;

  logic [8:0]     a;
  logic [CHW-1:0] cfg_ch;
  logic [2:0]     reg_sel;
  logic           ch_ok, wr_en, lock;
  logic [31:0]    rmux;
  logic           unused_addr;

  assign a           = cfg_addr_i[8:0];
  assign unused_addr = ^{cfg_addr_i[31:9], cfg_addr_i[1:0]};
  assign cfg_ch      = a[5 +: CHW];
  assign reg_sel     = a[4:2];
  assign ch_ok       = !a[8] && (int'(a[7:5]) < NumCh);
  assign wr_en       = cfg_req_i && cfg_we_i;
  assign busy        = (state != IDLE);
  assign lock        = busy && (cfg_ch == cur_q);
  assign cfg_gnt_o   = cfg_req_i;

  always_comb begin
    rmux = '0;
    if (a == 9'h100) rmux[NumCh-1:0] = irq_en_q;
    else if (ch_ok) begin
      case (reg_sel)
        3'd0: rmux = src_q[cfg_ch];
        3'd1: rmux = dst_q[cfg_ch];
        3'd2: rmux[CW-1:0] = len_q[cfg_ch];
        3'd3: rmux = stride_q[cfg_ch];
        3'd4: rmux[1:0] = {lock, pend_q[cfg_ch]};
        3'd5: rmux[1:0] = {err_q[cfg_ch], done_q[cfg_ch]};
        default: rmux = '0;
      endcase
    end
  end

  // Round-robin: first pending channel after the last one granted.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 1; i <= NumCh; i++) begin
      logic [CHW-1:0] idx;
      idx = CHW'((int'(last_q) + i) % NumCh);
      if (!found && pend_q[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign rd_req = (state == RUN) && !abort_q && (rd_iss < j_len) && ((out_cnt + fifo_cnt) < OW'(Depth));
  assign wr_req = (state == RUN) && !abort_q && (fifo_cnt != '0) && (wr_iss < j_len);
  assign rd_go  = rd_req && rd_gnt_i;
  assign wr_go  = wr_req && wr_gnt_i;
  assign rd_rsp = (state == RUN) && rd_rvalid_i;
  assign wr_rsp = (state == RUN) && wr_rvalid_i;
`ifdef NDMA_MC_ERR_EN
  assign err_hit = (rd_rsp && rd_err_i) || (wr_rsp && wr_err_i);
`else
  assign err_hit = 1'b0;
`endif
  assign push = rd_rsp && !abort_q && !err_hit;
  assign pop  = wr_go;

  assign rd_req_o   = rd_req;
  assign rd_addr_o  = rd_req ? rd_addr_q : '0;
  assign wr_req_o   = wr_req;
  assign wr_addr_o  = wr_req ? wr_addr_q : '0;
  assign wr_wdata_o = wr_req ? mem[rptr] : '0;
  assign wr_be_o    = {(DataWidth/8){wr_req}};
  assign irq_o      = irq_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    start   = 1'b0;
    finish  = 1'b0;
    case (state)
      IDLE: if (found) begin
        start   = 1'b1;
        state_n = (len_q[pick] == '0) ? DONE : RUN;
      end
      RUN: if (abort_q ? (out_cnt == '0 && wr_iss == wr_cnt) : (wr_cnt == j_len)) state_n = DONE;
      DONE: begin
        finish  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Completion set wins over a same-cycle write-1-to-clear.
  always_comb begin
    done_n = done_q;
    err_n  = err_q;
    if (wr_en && ch_ok && reg_sel == 3'd5) begin
      if (cfg_wdata_i[0]) done_n[cfg_ch] = 1'b0;
      if (cfg_wdata_i[1]) err_n[cfg_ch]  = 1'b0;
    end
    if (finish) begin
      done_n[cur_q] = 1'b1;
      if (abort_q) err_n[cur_q] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= rd_rdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int c = 0; c < NumCh; c++) begin
        src_q[c] <= '0; dst_q[c] <= '0; len_q[c] <= '0; stride_q[c] <= '0;
      end
      pend_q <= '0; done_q <= '0; err_q <= '0; irq_en_q <= '0; irq_q <= '0;
      cfg_rvalid_o <= 1'b0; cfg_rdata_o <= '0;
      cur_q <= '0; last_q <= CHW'(NumCh - 1); abort_q <= 1'b0;
      j_len <= '0; rd_iss <= '0; wr_iss <= '0; wr_cnt <= '0;
      rd_addr_q <= '0; wr_addr_q <= '0; j_ss <= '0; j_ds <= '0;
      out_cnt <= '0; fifo_cnt <= '0; wptr <= '0; rptr <= '0;
    end else begin
      cfg_rvalid_o <= cfg_req_i;
      cfg_rdata_o  <= (cfg_req_i && !cfg_we_i) ? rmux : '0;
      if (wr_en && a == 9'h100) irq_en_q <= cfg_wdata_i[NumCh-1:0];
      if (wr_en && ch_ok && !lock) begin
        case (reg_sel)
          3'd0: src_q[cfg_ch] <= cfg_wdata_i;
          3'd1: dst_q[cfg_ch] <= cfg_wdata_i;
          3'd2: len_q[cfg_ch] <= (cfg_wdata_i > 32'(MaxTxSize)) ? CW'(MaxTxSize) : cfg_wdata_i[CW-1:0];
          3'd3: stride_q[cfg_ch] <= cfg_wdata_i;
          default: ;
        endcase
      end
      // A pending set on the channel being launched survives as a queued rerun.
      if (start) pend_q[pick] <= 1'b0;
      if (wr_en && ch_ok && reg_sel == 3'd4 && cfg_wdata_i[0]) pend_q[cfg_ch] <= 1'b1;
      done_q <= done_n;
      err_q  <= err_n;
      irq_q  <= done_n & irq_en_q;

      if (start) begin
        cur_q <= pick; last_q <= pick; abort_q <= 1'b0;
        j_len <= len_q[pick];
        rd_addr_q <= src_q[pick]; wr_addr_q <= dst_q[pick];
        j_ss <= stride_q[pick][15:0]; j_ds <= stride_q[pick][31:16];
        rd_iss <= '0; wr_iss <= '0; wr_cnt <= '0;
        out_cnt <= '0; fifo_cnt <= '0; wptr <= '0; rptr <= '0;
      end else begin
        if (rd_go) begin
          rd_iss    <= rd_iss + CW'(1);
          rd_addr_q <= rd_addr_q + {16'b0, j_ss};
        end
        if (wr_go) begin
          wr_iss    <= wr_iss + CW'(1);
          wr_addr_q <= wr_addr_q + {16'b0, j_ds};
        end
        if (wr_rsp) wr_cnt <= wr_cnt + CW'(1);
        case ({rd_go, rd_rsp})
          2'b10:   out_cnt <= out_cnt + OW'(1);
          2'b01:   out_cnt <= out_cnt - OW'(1);
          default: ;
        endcase
        if (err_hit) abort_q <= 1'b1;
        if (abort_q || err_hit) begin
          fifo_cnt <= '0; wptr <= '0; rptr <= '0;
        end else begin
          if (push) wptr <= (wptr == PW'(Depth - 1)) ? '0 : wptr + PW'(1);
          if (pop)  rptr <= (rptr == PW'(Depth - 1)) ? '0 : rptr + PW'(1);
          case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + OW'(1);
            2'b01:   fifo_cnt <= fifo_cnt - OW'(1);
            default: ;
          endcase
        end
      end
    end
  end
endmodule
